// File: rtl/itype_exec_unit.sv
// Four-state executor for the MIPS I-type immediate ALU group (addi..lui).
// It owns its register file, which a combinational debug port can read.
module itype_exec_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  SYS_clk,
    input  logic                  SYS_reset,
    input  logic [31:0]           machineCode,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] ALU_result,
    output logic [7:0]            ALU_status,
    output logic                  result_valid,
    input  logic [4:0]            dbg_address,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int AW = $clog2(REG_COUNT);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_DECODE    = 2'd1;
    localparam logic [1:0] S_EXECUTE   = 2'd2;
    localparam logic [1:0] S_WRITEBACK = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [31:0]           instr_q, instr_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [7:0]            status_q, status_d;
    logic                  valid_q, valid_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] rf_d [REG_COUNT];

    logic [5:0]            opcode_s;
    logic [4:0]            rs_s, rt_s;
    logic [15:0]           imm_s;
    logic                  rs_oob_s, rt_oob_s, dbg_oob_s;
    logic [DATA_WIDTH-1:0] imm_ext_s;
    logic [DATA_WIDTH:0]   sum_s;
    logic [DATA_WIDTH-1:0] exe_res_s;
    logic                  exe_carry_s, exe_ovf_s, exe_sup_s;

    assign opcode_s  = instr_q[31:26];
    assign rs_s      = instr_q[25:21];
    assign rt_s      = instr_q[20:16];
    assign imm_s     = instr_q[15:0];
    assign rs_oob_s  = {1'b0, rs_s} >= 6'(REG_COUNT);
    assign rt_oob_s  = {1'b0, rt_s} >= 6'(REG_COUNT);
    assign dbg_oob_s = {1'b0, dbg_address} >= 6'(REG_COUNT);

    // Immediate extension: logical ops zero-extend, lui places imm in bits [31:16].
    always_comb begin
        imm_ext_s = {{(DATA_WIDTH-16){imm_s[15]}}, imm_s};
        case (opcode_s[2:0])
            3'd4, 3'd5, 3'd6: imm_ext_s = DATA_WIDTH'(imm_s);
            3'd7:             imm_ext_s = DATA_WIDTH'({imm_s, 16'h0000});
            default:          imm_ext_s = {{(DATA_WIDTH-16){imm_s[15]}}, imm_s};
        endcase
    end

    assign sum_s = {1'b0, opa_q} + {1'b0, opb_q};

    // ALU on the latched operands, plus the write-suppression decision.
    always_comb begin
        exe_res_s   = '0;
        exe_carry_s = 1'b0;
        exe_ovf_s   = 1'b0;
        case (op_q)
            3'd0, 3'd1: begin
                exe_res_s   = sum_s[DATA_WIDTH-1:0];
                exe_carry_s = sum_s[DATA_WIDTH];
                exe_ovf_s   = (opa_q[DATA_WIDTH-1] == opb_q[DATA_WIDTH-1]) &&
                              (sum_s[DATA_WIDTH-1] != opa_q[DATA_WIDTH-1]);
            end
            3'd2:    exe_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(opa_q) < $signed(opb_q))};
            3'd3:    exe_res_s = {{(DATA_WIDTH-1){1'b0}}, (opa_q < opb_q)};
            3'd4:    exe_res_s = opa_q & opb_q;
            3'd5:    exe_res_s = opa_q | opb_q;
            3'd6:    exe_res_s = opa_q ^ opb_q;
            3'd7:    exe_res_s = opb_q;
            default: exe_res_s = '0;
        endcase
        exe_sup_s = illegal_q || ((op_q == 3'd0) && exe_ovf_s) || (rt_s == 5'd0);
    end

    // Next-state and datapath register updates for the four-phase sequence.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        illegal_d = illegal_q;
        result_d  = result_q;
        status_d  = status_q;
        wr_en_d   = wr_en_q;
        valid_d   = 1'b0;
        rf_d      = rf_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = machineCode;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                illegal_d = (opcode_s[5:3] != 3'b001) || rs_oob_s || rt_oob_s;
                op_d      = opcode_s[2:0];
                opa_d     = rs_oob_s ? '0 : rf_q[rs_s[AW-1:0]];
                opb_d     = imm_ext_s;
                state_d   = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (illegal_q) begin
                    result_d = '0;
                    status_d = 8'h30;
                end else begin
                    result_d = exe_res_s;
                    status_d = {2'b00, exe_sup_s, 1'b0, exe_ovf_s, exe_carry_s,
                                exe_res_s[DATA_WIDTH-1], (exe_res_s == '0)};
                end
                wr_en_d = ~exe_sup_s;
                valid_d = 1'b1;
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                if (wr_en_q) begin
                    rf_d[rt_s[AW-1:0]] = result_q;
                end else begin
                    rf_d = rf_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; synchronous reset aborts any instruction in flight.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q   <= S_IDLE;
            instr_q   <= 32'h0000_0000;
            op_q      <= 3'd0;
            opa_q     <= '0;
            opb_q     <= '0;
            illegal_q <= 1'b0;
            result_q  <= '0;
            status_q  <= 8'h00;
            wr_en_q   <= 1'b0;
            valid_q   <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            illegal_q <= illegal_d;
            result_q  <= result_d;
            status_q  <= status_d;
            wr_en_q   <= wr_en_d;
            valid_q   <= valid_d;
            rf_q      <= rf_d;
        end
    end

    assign instr_ready  = (state_q == S_IDLE) && !SYS_reset;
    assign result_valid = valid_q && !SYS_reset;
    assign ALU_result   = result_q;
    assign ALU_status   = status_q;
    assign dbg_data     = (dbg_oob_s || (dbg_address == 5'd0)) ? '0 : rf_q[dbg_address[AW-1:0]];

endmodule
